// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter (fetch m0, data m1) with round-robin, burst-safe locking
// and a stall watchdog that aborts unacknowledged transfers.
module wb_bus_arbiter #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              m0_cyc,
   input  logic              m0_stb,
   input  logic [ADDR_W-1:0] m0_adr,
   input  logic              m0_4_burst,
   input  logic              m0_8_burst,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [DATA_W-1:0] m0_i_dat,
   input  logic              m1_cyc,
   input  logic              m1_stb,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_adr,
   input  logic [DATA_W-1:0] m1_o_dat,
   input  logic [1:0]        m1_sel,
   input  logic              m1_4_burst,
   input  logic              m1_8_burst,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [DATA_W-1:0] m1_i_dat,
   output logic              u_cyc,
   output logic              u_stb,
   output logic              u_we,
   output logic [ADDR_W-1:0] u_adr,
   output logic [DATA_W-1:0] u_o_dat,
   output logic [1:0]        u_sel,
   output logic              u_4_burst,
   output logic              u_8_burst,
   input  logic              u_ack,
   input  logic              u_err,
   input  logic [DATA_W-1:0] u_i_dat
);

   typedef enum logic [1:0] {IDLE, G0, G1, DRAIN} state_t;

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       last_q, last_d;   // 0: fetch granted last, 1: data granted last
   logic [7:0] wd_q, wd_d;

   logic req0, req1, gnt0, gnt1, stall, timeout_hit;

   assign req0 = m0_cyc & m0_stb;
   assign req1 = m1_cyc & m1_stb;
   assign gnt0 = (state_q == G0);
   assign gnt1 = (state_q == G1);

   assign stall       = (gnt0 | gnt1) & u_stb & ~u_ack & ~u_err;
   assign timeout_hit = stall & (wd_q == WD_LAST);

   // Read data is shared; only the owner's ack qualifies it.
   assign m0_i_dat = u_i_dat;
   assign m1_i_dat = u_i_dat;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      wd_d    = (stall && !timeout_hit) ? wd_q + 8'd1 : 8'd0;
      case (state_q)
         IDLE: begin
            if (req0 && (!req1 || last_q)) begin
               state_d = G0;
               last_d  = 1'b0;
            end else if (req1) begin
               state_d = G1;
               last_d  = 1'b1;
            end
         end
         G0: begin
            if (timeout_hit) begin
               state_d = DRAIN;
            end else if (!m0_cyc) begin
               if (req1) begin
                  state_d = G1;
                  last_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         G1: begin
            if (timeout_hit) begin
               state_d = DRAIN;
            end else if (!m1_cyc) begin
               if (req0) begin
                  state_d = G0;
                  last_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            // last_q still names the aborted owner
            if (!(last_q ? m1_cyc : m0_cyc)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      u_cyc     = 1'b0;
      u_stb     = 1'b0;
      u_we      = 1'b0;
      u_adr     = '0;
      u_o_dat   = '0;
      u_sel     = 2'b00;
      u_4_burst = 1'b0;
      u_8_burst = 1'b0;
      m0_ack    = 1'b0;
      m0_err    = 1'b0;
      m1_ack    = 1'b0;
      m1_err    = 1'b0;
      if (gnt0) begin
         u_cyc     = m0_cyc;
         u_stb     = m0_stb;
         u_adr     = m0_adr;
         u_sel     = 2'b11;
         u_4_burst = m0_4_burst;
         u_8_burst = m0_8_burst;
         m0_ack    = u_ack;
         m0_err    = u_err | timeout_hit;
      end else if (gnt1) begin
         u_cyc     = m1_cyc;
         u_stb     = m1_stb;
         u_we      = m1_we;
         u_adr     = m1_adr;
         u_o_dat   = m1_o_dat;
         u_sel     = m1_sel;
         u_4_burst = m1_4_burst;
         u_8_burst = m1_8_burst;
         m1_ack    = u_ack;
         m1_err    = u_err | timeout_hit;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter built with TIMEOUT=4; inputs change on the falling
// edge and outputs are sampled 1ns later.
module tb_wb_bus_arbiter;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] A0 = 24'h0A0000;
   localparam logic [ADDR_W-1:0] A1 = 24'h0B0000;

   logic i_clk = 1'b0;
   logic i_rst;
   logic m0_cyc, m0_stb, m0_4_burst, m0_8_burst, m0_ack, m0_err;
   logic [ADDR_W-1:0] m0_adr;
   logic [DATA_W-1:0] m0_i_dat;
   logic m1_cyc, m1_stb, m1_we, m1_4_burst, m1_8_burst, m1_ack, m1_err;
   logic [ADDR_W-1:0] m1_adr;
   logic [DATA_W-1:0] m1_o_dat, m1_i_dat;
   logic [1:0] m1_sel;
   logic u_cyc, u_stb, u_we, u_4_burst, u_8_burst, u_ack, u_err;
   logic [ADDR_W-1:0] u_adr;
   logic [DATA_W-1:0] u_o_dat, u_i_dat;
   logic [1:0] u_sel;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   wb_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_adr(m0_adr),
      .m0_4_burst(m0_4_burst), .m0_8_burst(m0_8_burst),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_i_dat(m0_i_dat),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
      .m1_o_dat(m1_o_dat), .m1_sel(m1_sel),
      .m1_4_burst(m1_4_burst), .m1_8_burst(m1_8_burst),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_i_dat(m1_i_dat),
      .u_cyc(u_cyc), .u_stb(u_stb), .u_we(u_we), .u_adr(u_adr),
      .u_o_dat(u_o_dat), .u_sel(u_sel),
      .u_4_burst(u_4_burst), .u_8_burst(u_8_burst),
      .u_ack(u_ack), .u_err(u_err), .u_i_dat(u_i_dat)
   );

   task automatic nxt();
      @(negedge i_clk);
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      m0_cyc = 0; m0_stb = 0; m0_adr = A0; m0_4_burst = 0; m0_8_burst = 0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = A1; m1_o_dat = '0; m1_sel = 2'b00;
      m1_4_burst = 0; m1_8_burst = 0;
      u_ack = 0; u_err = 0; u_i_dat = '0;
      nxt(); nxt();
      #1;
      checks++;
      if ({u_cyc, u_stb, u_we, u_4_burst, u_8_burst} !== 5'b0) begin
         errors++; $display("FAIL reset_ctl: got %b expected 00000", {u_cyc, u_stb, u_we, u_4_burst, u_8_burst});
      end
      checks++;
      if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0) begin
         errors++; $display("FAIL reset_resp: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err});
      end
      checks++;
      if (u_adr !== '0 || u_o_dat !== '0 || u_sel !== 2'b00) begin
         errors++; $display("FAIL reset_data: got adr=%h dat=%h sel=%b expected 0", u_adr, u_o_dat, u_sel);
      end
      i_rst = 1'b0;
   endtask

   task automatic test_basic_read();
      nxt();
      m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000100;
      #1;
      checks++;
      if (u_cyc !== 1'b0) begin
         errors++; $display("FAIL read_latency: got u_cyc=%b expected 0", u_cyc);
      end
      nxt(); #1;
      checks++;
      if (u_cyc !== 1'b1 || u_stb !== 1'b1 || u_adr !== 24'h000100 || u_we !== 1'b0 || u_sel !== 2'b11) begin
         errors++; $display("FAIL read_grant: got cyc=%b stb=%b adr=%h we=%b sel=%b expected 1 1 000100 0 11",
                            u_cyc, u_stb, u_adr, u_we, u_sel);
      end
      u_ack = 1; u_i_dat = 16'hBEEF;
      #1;
      checks++;
      if (m0_ack !== 1'b1 || m0_i_dat !== 16'hBEEF || m1_ack !== 1'b0) begin
         errors++; $display("FAIL read_ack: got m0_ack=%b dat=%h m1_ack=%b expected 1 beef 0", m0_ack, m0_i_dat, m1_ack);
      end
      nxt();
      u_ack = 0; m0_cyc = 0; m0_stb = 0; m0_adr = A0;
      #1;
      checks++;
      if (u_cyc !== 1'b0) begin
         errors++; $display("FAIL read_release: got u_cyc=%b expected 0", u_cyc);
      end
   endtask

   task automatic test_round_robin();
      logic [ADDR_W-1:0] exp_adr;
      i_rst = 1; #1; i_rst = 0;
      nxt();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_we = 1;
      nxt(); #1;
      checks++;
      if (u_adr !== A0 || u_we !== 1'b0) begin
         errors++; $display("FAIL tie_first: got adr=%h we=%b expected %h 0", u_adr, u_we, A0);
      end
      nxt();
      m0_cyc = 0; m0_stb = 0;
      #1;
      checks++;
      if (u_cyc !== 1'b0) begin
         errors++; $display("FAIL handoff_gap: got u_cyc=%b expected 0", u_cyc);
      end
      nxt(); #1;
      checks++;
      if (u_cyc !== 1'b1 || u_adr !== A1 || u_we !== 1'b1) begin
         errors++; $display("FAIL handoff_g1: got cyc=%b adr=%h we=%b expected 1 %h 1", u_cyc, u_adr, u_we, A1);
      end
      nxt();
      m1_cyc = 0; m1_stb = 0; m1_we = 0;
      for (int i = 0; i < 4; i++) begin
         nxt();
         m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
         exp_adr = (i % 2 == 0) ? A0 : A1;
         nxt(); #1;
         checks++;
         if (u_cyc !== 1'b1 || u_adr !== exp_adr) begin
            errors++; $display("FAIL rr_alt[%0d]: got cyc=%b adr=%h expected 1 %h", i, u_cyc, u_adr, exp_adr);
         end
         m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
         nxt();
      end
   endtask

   task automatic test_burst_lock();
      nxt();
      m0_cyc = 1; m0_stb = 1; m0_8_burst = 1;
      nxt();
      for (int b = 0; b < 8; b++) begin
         u_ack = 1; u_i_dat = 16'(b);
         if (b == 2) begin m1_cyc = 1; m1_stb = 1; end
         #1;
         checks++;
         if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || u_8_burst !== 1'b1 || u_adr !== A0) begin
            errors++; $display("FAIL burst_beat[%0d]: got m0_ack=%b m1_ack=%b b8=%b adr=%h expected 1 0 1 %h",
                               b, m0_ack, m1_ack, u_8_burst, u_adr, A0);
         end
         nxt();
      end
      u_ack = 0; m0_cyc = 0; m0_stb = 0; m0_8_burst = 0;
      #1;
      checks++;
      if (u_cyc !== 1'b0 || m1_ack !== 1'b0) begin
         errors++; $display("FAIL burst_end: got cyc=%b m1_ack=%b expected 0 0", u_cyc, m1_ack);
      end
      nxt(); #1;
      checks++;
      if (u_cyc !== 1'b1 || u_adr !== A1 || u_8_burst !== 1'b0) begin
         errors++; $display("FAIL burst_handoff: got cyc=%b adr=%h b8=%b expected 1 %h 0", u_cyc, u_adr, u_8_burst, A1);
      end
      u_ack = 1;
      #1;
      checks++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
         errors++; $display("FAIL burst_m1_ack: got m1_ack=%b m0_ack=%b expected 1 0", m1_ack, m0_ack);
      end
      nxt();
      u_ack = 0; m1_cyc = 0; m1_stb = 0;
   endtask

   task automatic test_write();
      nxt();
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 2'b01; m1_o_dat = 16'h00A5;
      nxt(); #1;
      checks++;
      if (u_we !== 1'b1 || u_sel !== 2'b01 || u_o_dat !== 16'h00A5 || u_adr !== A1) begin
         errors++; $display("FAIL write_mux: got we=%b sel=%b dat=%h adr=%h expected 1 01 00a5 %h",
                            u_we, u_sel, u_o_dat, u_adr, A1);
      end
      u_ack = 1;
      #1;
      checks++;
      if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
         errors++; $display("FAIL write_ack: got m1_ack=%b m0_ack=%b expected 1 0", m1_ack, m0_ack);
      end
      nxt();
      u_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 2'b00; m1_o_dat = '0;
   endtask

   task automatic test_timeout();
      nxt();
      m1_cyc = 1; m1_stb = 1;
      nxt();
      for (int s = 1; s <= 4; s++) begin
         if (s == 2) begin m0_cyc = 1; m0_stb = 1; end
         #1;
         checks++;
         if (u_cyc !== 1'b1 || m1_err !== (s == 4) || m0_err !== 1'b0) begin
            errors++; $display("FAIL stall[%0d]: got cyc=%b m1_err=%b m0_err=%b expected 1 %b 0",
                               s, u_cyc, m1_err, m0_err, (s == 4));
         end
         nxt();
      end
      for (int d = 0; d < 2; d++) begin
         #1;
         checks++;
         if (u_cyc !== 1'b0 || u_stb !== 1'b0 || m1_err !== 1'b0 || m0_ack !== 1'b0) begin
            errors++; $display("FAIL drain[%0d]: got cyc=%b stb=%b m1_err=%b m0_ack=%b expected 0 0 0 0",
                               d, u_cyc, u_stb, m1_err, m0_ack);
         end
         nxt();
      end
      m1_cyc = 0; m1_stb = 0;
      nxt(); #1;
      checks++;
      if (u_cyc !== 1'b0) begin
         errors++; $display("FAIL drain_idle: got u_cyc=%b expected 0", u_cyc);
      end
      nxt(); #1;
      checks++;
      if (u_cyc !== 1'b1 || u_adr !== A0) begin
         errors++; $display("FAIL drain_regrant: got cyc=%b adr=%h expected 1 %h", u_cyc, u_adr, A0);
      end
      m0_cyc = 0; m0_stb = 0;
      nxt();
   endtask

   task automatic test_reset_mid_burst();
      nxt();
      m0_cyc = 1; m0_stb = 1; m0_4_burst = 1;
      nxt();
      for (int b = 0; b < 2; b++) begin
         u_ack = 1;
         nxt();
      end
      u_ack = 0;
      #1;
      checks++;
      if (u_cyc !== 1'b1 || u_4_burst !== 1'b1) begin
         errors++; $display("FAIL rst_pre: got cyc=%b b4=%b expected 1 1", u_cyc, u_4_burst);
      end
      m1_cyc = 1; m1_stb = 1;
      i_rst = 1;
      #1;
      checks++;
      if (u_cyc !== 1'b0 || u_4_burst !== 1'b0 || m0_err !== 1'b0 || m1_err !== 1'b0) begin
         errors++; $display("FAIL rst_async: got cyc=%b b4=%b m0_err=%b m1_err=%b expected 0 0 0 0",
                            u_cyc, u_4_burst, m0_err, m1_err);
      end
      #1; i_rst = 0;
      nxt(); #1;
      checks++;
      if (u_cyc !== 1'b1 || u_adr !== A0 || u_4_burst !== 1'b1) begin
         errors++; $display("FAIL rst_regrant: got cyc=%b adr=%h b4=%b expected 1 %h 1", u_cyc, u_adr, u_4_burst, A0);
      end
      m0_cyc = 0; m0_stb = 0; m0_4_burst = 0; m1_cyc = 0; m1_stb = 0;
      nxt();
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_round_robin();
      test_burst_lock();
      test_write();
      test_timeout();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout: bench exceeded its time limit");
      $fatal(1);
   end

endmodule
